// File: rtl/gate_trigger_sequencer.sv
// Trigger pulse-train generator: a start edge while armed emits N single-cycle trig_o pulses
// spaced period_cycles_i apart (continuous when N=0), with busy/done/count status.
module gate_trigger_sequencer #(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    arm_i,
  input  logic                    sw_trig_i,
  input  logic                    ext_trig_i,
  input  logic                    ext_trig_en_i,
  input  logic [PERIOD_WIDTH-1:0] period_cycles_i,
  input  logic [COUNT_WIDTH-1:0]  n_pulses_i,
  output logic                    trig_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [COUNT_WIDTH-1:0]  pulse_count_o
);

  typedef enum logic [1:0] {StIdle, StFire, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    sw_q, sw_prev_q;
  logic                    ext_sync1_q, ext_sync2_q, ext_q, ext_prev_q;
  logic                    start_q;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] wait_q, wait_d;
  logic [COUNT_WIDTH-1:0]  n_q, n_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d, count_inc;
  logic                    trig_q, busy_q, done_q;
  logic                    sw_edge, ext_edge;

  assign sw_edge   = sw_q & ~sw_prev_q;
  assign ext_edge  = ext_q & ~ext_prev_q;
  assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    wait_d   = wait_q;
    n_d      = n_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (start_q && arm_i) begin
          state_d  = StFire;
          period_d = (period_cycles_i == '0) ? PERIOD_WIDTH'(1) : period_cycles_i;
          n_d      = n_pulses_i;
          count_d  = COUNT_WIDTH'(1);
        end
      end
      StFire: begin
        if (!arm_i) begin
          state_d = StIdle;
        end else if ((n_q != '0) && (count_q == n_q)) begin
          state_d = StDone;
        end else if (period_q == PERIOD_WIDTH'(1)) begin
          state_d = StFire;
          count_d = count_inc;
        end else begin
          // FIRE and the final WAIT cycle (counter at 0) each take one clock of the period
          wait_d  = period_q - PERIOD_WIDTH'(2);
          state_d = StWait;
        end
      end
      StWait: begin
        if (!arm_i) begin
          state_d = StIdle;
        end else if (wait_q == '0) begin
          state_d = StFire;
          count_d = count_inc;
        end else begin
          wait_d = wait_q - PERIOD_WIDTH'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sw_q        <= 1'b0;
      sw_prev_q   <= 1'b0;
      ext_sync1_q <= 1'b0;
      ext_sync2_q <= 1'b0;
      ext_q       <= 1'b0;
      ext_prev_q  <= 1'b0;
      start_q     <= 1'b0;
      period_q    <= '0;
      wait_q      <= '0;
      n_q         <= '0;
      count_q     <= '0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sw_q        <= sw_trig_i;
      sw_prev_q   <= sw_q;
      ext_sync1_q <= ext_trig_i;
      ext_sync2_q <= ext_sync1_q;
      ext_q       <= ext_sync2_q;
      ext_prev_q  <= ext_q;
      start_q     <= arm_i & (sw_edge | (ext_trig_en_i & ext_edge));
      state_q     <= state_d;
      period_q    <= period_d;
      wait_q      <= wait_d;
      n_q         <= n_d;
      count_q     <= count_d;
      trig_q      <= (state_d == StFire);
      busy_q      <= (state_d == StFire) || (state_d == StWait);
      done_q      <= (state_d == StDone);
    end
  end

  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pulse_count_o = count_q;

endmodule

// File: tb/tb_gate_trigger_sequencer.sv
// Directed bench for gate_trigger_sequencer: burst timing, ext path, continuous/abort,
// period 0/1, input changes mid-burst, held triggers and asynchronous reset.
module tb_gate_trigger_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, arm, sw, ext, ext_en;
  logic [31:0] period;
  logic [15:0] npul;
  logic        trig, busy, done;
  logic [15:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  gate_trigger_sequencer #(
    .PERIOD_WIDTH(32),
    .COUNT_WIDTH (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .arm_i          (arm),
    .sw_trig_i      (sw),
    .ext_trig_i     (ext),
    .ext_trig_en_i  (ext_en),
    .period_cycles_i(period),
    .n_pulses_i     (npul),
    .trig_o         (trig),
    .busy_o         (busy),
    .done_o         (done),
    .pulse_count_o  (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge 0, the first edge sampling sw=1.
  task automatic sw_start();
    sw = 1'b0;
    repeat (3) step();
    sw = 1'b1;
    step();
  endtask

  // Checks cycles 0..ncyc after edge 0 against a burst whose first pulse is at cycle f.
  task automatic burst_check(input int f, input int p, input int n, input int ncyc,
                             input bit disturb);
    bit exp_trig, exp_busy, exp_done;
    int nf;
    for (int c = 0; c <= ncyc; c++) begin
      exp_trig = (c >= f) && (((c - f) % p) == 0) && (((c - f) / p) < n);
      exp_busy = (c >= f) && (c <= f + (n - 1) * p);
      exp_done = (c == f + (n - 1) * p + 1);
      check("burst_trig", trig, exp_trig);
      check("burst_busy", busy, exp_busy);
      check("burst_done", done, exp_done);
      if (c >= f) begin
        nf = (c - f) / p + 1;
        if (nf > n) nf = n;
        check("burst_count", count, nf);
      end
      if (disturb) begin
        if (c == 5) begin
          period = 3;
          npul   = 7;
          sw     = 1'b0;
        end
        if (c == 8) sw = 1'b1;
      end
      if (c < ncyc) step();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    arm    = 1'b0;
    sw     = 1'b0;
    ext    = 1'b0;
    ext_en = 1'b0;
    period = 10;
    npul   = 3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    repeat (2) step();
    arm = 1'b1;

    // Basic burst: period 10, N=3.
    sw_start();
    burst_check(2, 10, 3, 26, 1'b0);

    // Same burst while toggling sw and changing period/N mid-burst.
    sw_start();
    burst_check(2, 10, 3, 26, 1'b1);
    for (int c = 0; c < 15; c++) begin
      step();
      check("held_trig", trig, 0);
      check("held_busy", busy, 0);
    end
    period = 10;
    npul   = 3;

    // period 0 and 1 behave identically: back-to-back pulses.
    period = 0;
    npul   = 5;
    sw_start();
    burst_check(2, 1, 5, 10, 1'b0);
    period = 1;
    sw_start();
    burst_check(2, 1, 5, 10, 1'b0);

    // External trigger, enabled then disabled.
    sw     = 1'b0;
    period = 5;
    npul   = 2;
    ext_en = 1'b1;
    step();
    #3 ext = 1'b1;
    @(posedge clk);
    #1;
    burst_check(4, 5, 2, 12, 1'b0);
    ext = 1'b0;
    repeat (5) step();
    ext_en = 1'b0;
    #3 ext = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 12; c++) begin
      check("ext_dis_trig", trig, 0);
      check("ext_dis_busy", busy, 0);
      step();
    end
    ext = 1'b0;

    // Disarmed: start edge ignored.
    arm = 1'b0;
    sw_start();
    for (int c = 0; c < 8; c++) begin
      check("disarm_trig", trig, 0);
      step();
    end
    arm = 1'b1;

    // Continuous mode, then abort via arm.
    period = 4;
    npul   = 0;
    sw_start();
    for (int c = 0; c <= 41; c++) begin
      check("cont_trig", trig, (c >= 2) && (((c - 2) % 4) == 0));
      check("cont_busy", busy, c >= 2);
      check("cont_done", done, 0);
      if (c < 41) step();
    end
    arm = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_trig", trig, 0);
    check("abort_count", count, 10);
    for (int c = 0; c < 5; c++) begin
      step();
      check("abort_done", done, 0);
      check("abort_hold_count", count, 10);
    end
    arm = 1'b1;

    // Asynchronous reset during WAIT, then a clean burst.
    period = 10;
    npul   = 3;
    sw_start();
    repeat (5) step();
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    sw = 1'b0;
    #1;
    check("mid_rst_trig", trig, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    sw_start();
    burst_check(2, 10, 3, 26, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
